code_entry_checker: RTL and testbench

//  Consumes debounced keypad digits and compares the entered sequence against a

---
 rtl/code_entry_checker.sv | 152 +++++++++++++++
 tb/tb_code_entry_checker.sv | 119 +++++++++++
 2 files changed

// File: rtl/code_entry_checker.sv
// rtl/code_entry_checker.sv - keypad code comparator with entry timeout, clear key and failure lockout
// Outputs are registered and change together with the state register.
module code_entry_checker #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] CODE           = 16'h1234,
  parameter logic [31:0]           HOLD_CYCLES    = 32'd100000,
  parameter logic [31:0]           TIMEOUT_CYCLES = 32'd500000000,
  parameter int                    MAX_FAILS      = 3,
  parameter logic [31:0]           LOCKOUT_CYCLES = 32'd1000000000
) (
  input  logic       CLK100MHZ,
  input  logic       reset_in,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       success,
  output logic       error,
  output logic       locked,
  output logic [2:0] digits_entered
);

  typedef enum logic [2:0] {IDLE, ENTRY, SUCCESS, ERROR, LOCKOUT} state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [2:0] LAST_IDX  = 3'(CODE_LEN - 1);
  localparam logic [7:0] FAIL_MAX  = 8'(MAX_FAILS);

  state_t      state_q;
  logic [31:0] timer_q;
  logic [7:0]  fail_q;
  logic        mismatch_q;
  logic        success_q;
  logic        error_q;
  logic        locked_q;
  logic [2:0]  digits_entered_q;

  logic [3:0]  exp_digit;
  logic [31:0] timer_inc;
  logic [7:0]  fail_sat;
  logic        is_digit;

  // digits_entered_q is 0 in IDLE, so it also selects the first digit there
  always_comb begin
    exp_digit = 4'h0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digits_entered_q == 3'(i)) exp_digit = CODE[4*(CODE_LEN-1-i) +: 4];
    end
  end

  assign timer_inc = timer_q + 32'd1;
  assign fail_sat  = (fail_q == FAIL_MAX) ? fail_q : fail_q + 8'd1;
  assign is_digit  = key_valid && (key_code != KEY_CLEAR);

  always_ff @(posedge CLK100MHZ or negedge reset_in) begin
    if (!reset_in) begin
      state_q          <= IDLE;
      timer_q          <= 32'd0;
      fail_q           <= 8'd0;
      mismatch_q       <= 1'b0;
      success_q        <= 1'b0;
      error_q          <= 1'b0;
      locked_q         <= 1'b0;
      digits_entered_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_digit) begin
            state_q          <= ENTRY;
            timer_q          <= 32'd0;
            mismatch_q       <= (key_code != exp_digit);
            digits_entered_q <= 3'd1;
          end
        end
        ENTRY: begin
          if (key_valid && !is_digit) begin
            state_q          <= IDLE;
            timer_q          <= 32'd0;
            mismatch_q       <= 1'b0;
            digits_entered_q <= 3'd0;
          end else if (is_digit) begin
            timer_q <= 32'd0;
            if (digits_entered_q == LAST_IDX) begin
              mismatch_q       <= 1'b0;
              digits_entered_q <= 3'd0;
              if (mismatch_q || (key_code != exp_digit)) begin
                state_q <= ERROR;
                error_q <= 1'b1;
                fail_q  <= fail_sat;
              end else begin
                state_q   <= SUCCESS;
                success_q <= 1'b1;
                fail_q    <= 8'd0;
              end
            end else begin
              mismatch_q       <= mismatch_q | (key_code != exp_digit);
              digits_entered_q <= digits_entered_q + 3'd1;
            end
          end else if (timer_inc == TIMEOUT_CYCLES) begin
            state_q          <= ERROR;
            timer_q          <= 32'd0;
            error_q          <= 1'b1;
            fail_q           <= fail_sat;
            mismatch_q       <= 1'b0;
            digits_entered_q <= 3'd0;
          end else begin
            timer_q <= timer_inc;
          end
        end
        SUCCESS: begin
          if (timer_inc == HOLD_CYCLES) begin
            state_q   <= IDLE;
            timer_q   <= 32'd0;
            success_q <= 1'b0;
          end else begin
            timer_q <= timer_inc;
          end
        end
        ERROR: begin
          if (timer_inc == HOLD_CYCLES) begin
            timer_q <= 32'd0;
            if (fail_q == FAIL_MAX) begin
              state_q  <= LOCKOUT;
              locked_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              error_q <= 1'b0;
            end
          end else begin
            timer_q <= timer_inc;
          end
        end
        LOCKOUT: begin
          if (timer_inc == LOCKOUT_CYCLES) begin
            state_q  <= IDLE;
            timer_q  <= 32'd0;
            error_q  <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 8'd0;
          end else begin
            timer_q <= timer_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign success        = success_q;
  assign error          = error_q;
  assign locked         = locked_q;
  assign digits_entered = digits_entered_q;

endmodule

// File: tb/tb_code_entry_checker.sv
// tb/tb_code_entry_checker.sv - directed bench for code_entry_checker
// Observed vector is {success, error, locked, digits_entered}.
module tb_code_entry_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       success, error, locked;
  logic [2:0] digits_entered;
  int         n_tests = 0;
  int         n_fail = 0;

  code_entry_checker #(
    .CODE_LEN(4), .CODE(16'h1234), .HOLD_CYCLES(32'd8), .TIMEOUT_CYCLES(32'd20),
    .MAX_FAILS(3), .LOCKOUT_CYCLES(32'd30)
  ) dut (
    .CLK100MHZ(clk), .reset_in(rst_n), .key_valid(key_valid), .key_code(key_code),
    .success(success), .error(error), .locked(locked), .digits_entered(digits_entered)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OUT_IDLE = 6'b000000;
  localparam logic [5:0] OUT_OK   = 6'b100000;
  localparam logic [5:0] OUT_ERR  = 6'b010000;
  localparam logic [5:0] OUT_LOCK = 6'b011000;

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {success, error, locked, digits_entered};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk); key_valid = 1'b1; key_code = d;
    @(negedge clk); key_valid = 1'b0;
  endtask

  task automatic hold(input string tag, input logic [5:0] exp, input int n);
    check(tag, exp);
    repeat (n - 1) begin
      @(negedge clk);
      check(tag, exp);
    end
  endtask

  task automatic enter_code(input string tag, input logic [15:0] c, input bit ok, input bit to_idle);
    for (int i = 3; i >= 1; i--) begin
      press(c[4*i +: 4]);
      check({tag, "_digit"}, {3'b000, 3'(4 - i)});
    end
    press(c[3:0]);
    hold({tag, "_hold"}, ok ? OUT_OK : OUT_ERR, 8);
    if (to_idle) begin
      @(negedge clk);
      check({tag, "_idle"}, OUT_IDLE);
    end
  endtask

  initial begin
    #23;
    check("reset", OUT_IDLE);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); check("idle", OUT_IDLE);
    press(4'hF); check("clear_in_idle", OUT_IDLE);

    enter_code("t1_ok", 16'h1234, 1'b1, 1'b1);
    enter_code("t2_bad", 16'h1934, 1'b0, 1'b1);

    press(4'h1); check("t3_d1", 6'd1);
    press(4'h2); check("t3_d2", 6'd2);
    press(4'hF); check("t3_clear", OUT_IDLE);
    enter_code("t3_ok", 16'h1234, 1'b1, 1'b1);

    press(4'h1); check("t4_d1", 6'd1);
    repeat (19) @(negedge clk);
    check("t4_before_timeout", 6'd1);
    @(negedge clk);
    hold("t4_timeout", OUT_ERR, 8);
    @(negedge clk); check("t4_idle", OUT_IDLE);

    // the timeout already counted once, so two wrong codes reach the limit
    enter_code("t5_bad1", 16'h5555, 1'b0, 1'b1);
    enter_code("t5_bad2", 16'h1235, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      key_valid = 1'b1;
      key_code = 4'(i % 4 + 1);
      @(negedge clk);
      check("t5_locked", OUT_LOCK);
    end
    key_valid = 1'b0;
    @(negedge clk); check("t5_unlocked", OUT_IDLE);
    enter_code("t5_ok", 16'h1234, 1'b1, 1'b1);

    press(4'h1); press(4'h2); check("t6_mid_entry", 6'd2);
    #2 rst_n = 1'b0;
    #1 check("t6_async_entry", OUT_IDLE);
    @(negedge clk); rst_n = 1'b1;
    enter_code("t6_ok1", 16'h1234, 1'b1, 1'b1);
    enter_code("t6_bad1", 16'h0000, 1'b0, 1'b1);
    enter_code("t6_bad2", 16'h4321, 1'b0, 1'b1);
    enter_code("t6_bad3", 16'h1230, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("t6_in_lockout", OUT_LOCK);
    #2 rst_n = 1'b0;
    #1 check("t6_async_lockout", OUT_IDLE);
    @(negedge clk); rst_n = 1'b1;
    enter_code("t6_ok2", 16'h1234, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
